// File: rtl/key_conditioner.sv
// Multi-channel key conditioner: 2-flop synchronizer, counter debounce,
// press/release edge pulses and a per-channel auto-repeat FSM.
module key_conditioner #(
  parameter int unsigned N             = 4,
  parameter int unsigned DEBOUNCE      = 16,
  parameter int unsigned ACTIVE_LOW    = 1,
  parameter int unsigned HOLD_DELAY    = 8,
  parameter int unsigned REPEAT_PERIOD = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         repeat_en,
  input  logic [N-1:0] key,
  output logic [N-1:0] press,
  output logic [N-1:0] rel,
  output logic [N-1:0] held
);

  localparam int unsigned CW   = $clog2(DEBOUNCE + 1);
  localparam int unsigned RMAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  // Raw level of a released key; synchronizers reset to it so nothing looks pressed
  localparam logic [N-1:0] RELEASED = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DELAY  = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  logic [N-1:0]    sync1;
  logic [N-1:0]    sync2;
  logic [N-1:0]    level;
  logic [N-1:0]    db;
  logic [N-1:0]    db_d;
  logic [N-1:0]    press_d;
  logic [N-1:0]    rel_d;
  logic [N-1:0]    rise;
  logic [N-1:0]    fall;
  logic [N-1:0]    rep;
  logic [CW-1:0]   cnt_q  [N];
  logic [CW-1:0]   cnt_d  [N];
  logic [1:0]      st_q   [N];
  logic [1:0]      st_d   [N];
  logic [RW-1:0]   rcnt_q [N];
  logic [RW-1:0]   rcnt_d [N];

  assign level = (ACTIVE_LOW != 0) ? ~sync2 : sync2;
  assign held  = db;

  // Debounce, edge detection and repeat next-state for every channel
  always_comb begin
    db_d    = db;
    press_d = '0;
    rel_d   = '0;
    rise    = '0;
    fall    = '0;
    rep     = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i]  = cnt_q[i];
      st_d[i]   = st_q[i];
      rcnt_d[i] = rcnt_q[i];

      if (level[i] == db[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CW'(DEBOUNCE - 1)) begin
        cnt_d[i] = '0;
        db_d[i]  = level[i];
        rise[i]  = level[i];
        fall[i]  = ~level[i];
      end else begin
        cnt_d[i] = CW'(cnt_q[i] + 1'b1);
      end

      case (st_q[i])
        S_IDLE: begin
          rcnt_d[i] = '0;
          if (rise[i] && repeat_en) st_d[i] = S_DELAY;
        end
        S_DELAY: begin
          if (rcnt_q[i] == RW'(HOLD_DELAY - 1)) begin
            st_d[i]   = S_REPEAT;
            rcnt_d[i] = '0;
            rep[i]    = 1'b1;
          end else begin
            rcnt_d[i] = RW'(rcnt_q[i] + 1'b1);
          end
        end
        S_REPEAT: begin
          if (rcnt_q[i] == RW'(REPEAT_PERIOD - 1)) begin
            rcnt_d[i] = '0;
            rep[i]    = 1'b1;
          end else begin
            rcnt_d[i] = RW'(rcnt_q[i] + 1'b1);
          end
        end
        default: begin
          st_d[i]   = S_IDLE;
          rcnt_d[i] = '0;
        end
      endcase

      // Release or disable wins over a due repeat so it never lands with rel
      if (st_q[i] != S_IDLE && (fall[i] || !repeat_en)) begin
        st_d[i]   = S_IDLE;
        rcnt_d[i] = '0;
        rep[i]    = 1'b0;
      end

      press_d[i] = rise[i] | rep[i];
      rel_d[i]   = fall[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= RELEASED;
      sync2 <= RELEASED;
      db    <= '0;
      press <= '0;
      rel   <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i]  <= '0;
        st_q[i]   <= S_IDLE;
        rcnt_q[i] <= '0;
      end
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      db    <= db_d;
      press <= press_d;
      rel   <= rel_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i]  <= cnt_d[i];
        st_q[i]   <= st_d[i];
        rcnt_q[i] <= rcnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: per-cycle vector table plus
// hand-built sequences for repeat enable, repeat abort and reset mid-repeat.
module tb_key_conditioner;

  localparam int unsigned N = 4;

  logic         clk;
  logic         reset;
  logic         repeat_en;
  logic [N-1:0] key;
  logic [N-1:0] press;
  logic [N-1:0] rel;
  logic [N-1:0] held;

  int tests;
  int fails;

  key_conditioner #(
    .N(N), .DEBOUNCE(4), .ACTIVE_LOW(1), .HOLD_DELAY(8), .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk), .reset(reset), .repeat_en(repeat_en), .key(key),
    .press(press), .rel(rel), .held(held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] k;
    logic         ren;
    logic [N-1:0] p;
    logic [N-1:0] r;
    logic [N-1:0] h;
    string        name;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input string name, input logic [N-1:0] k, input logic ren,
                              input logic [N-1:0] p, input logic [N-1:0] r,
                              input logic [N-1:0] h, input int count);
    vec_t v;
    v.k = k; v.ren = ren; v.p = p; v.r = r; v.h = h; v.name = name;
    for (int i = 0; i < count; i++) tbl.push_back(v);
  endfunction

  task automatic compare(input string name, input int idx,
                         input logic [N-1:0] p, input logic [N-1:0] r, input logic [N-1:0] h);
    tests++;
    if (press !== p || rel !== r || held !== h) begin
      fails++;
      $display("FAIL %s[%0d]: press/rel/held got %h/%h/%h want %h/%h/%h",
               name, idx, press, rel, held, p, r, h);
    end
  endtask

  // Drive inputs, advance one edge, check outputs 1 time unit later
  task automatic step(input string name, input int idx, input logic rst, input logic [N-1:0] k,
                      input logic ren, input logic [N-1:0] p, input logic [N-1:0] r,
                      input logic [N-1:0] h);
    reset     = rst;
    key       = k;
    repeat_en = ren;
    @(posedge clk);
    #1;
    compare(name, idx, p, r, h);
  endtask

  initial begin
    logic [N-1:0] ep;
    logic [N-1:0] er;
    logic [N-1:0] eh;
    tests = 0;
    fails = 0;
    reset = 1'b0;
    key = 4'hF;
    repeat_en = 1'b0;

    // Single press on key0, no repeat, then release
    add("k0_idle",     4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 2);
    add("k0_deb",      4'hE, 1'b0, 4'h0, 4'h0, 4'h0, 5);
    add("k0_press",    4'hE, 1'b0, 4'h1, 4'h0, 4'h1, 1);
    add("k0_hold",     4'hE, 1'b0, 4'h0, 4'h0, 4'h1, 14);
    add("k0_reldeb",   4'hF, 1'b0, 4'h0, 4'h0, 4'h1, 5);
    add("k0_rel",      4'hF, 1'b0, 4'h0, 4'h1, 4'h0, 1);
    add("k0_after",    4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 3);
    // Bouncing key1 never accepted
    add("k1_bounce_a", 4'hD, 1'b0, 4'h0, 4'h0, 4'h0, 3);
    add("k1_bounce_b", 4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 1);
    add("k1_bounce_c", 4'hD, 1'b0, 4'h0, 4'h0, 4'h0, 3);
    add("k1_bounce_d", 4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 8);
    // key0 and key3 together
    add("k03_deb",     4'h6, 1'b0, 4'h0, 4'h0, 4'h0, 5);
    add("k03_press",   4'h6, 1'b0, 4'h9, 4'h0, 4'h9, 1);
    add("k03_hold",    4'h6, 1'b0, 4'h0, 4'h0, 4'h9, 3);
    add("k03_reldeb",  4'hF, 1'b0, 4'h0, 4'h0, 4'h9, 5);
    add("k03_rel",     4'hF, 1'b0, 4'h0, 4'h9, 4'h0, 1);
    add("k03_after",   4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 2);
    // key2 auto-repeat: press at P, then P+8, P+11, ...
    add("k2_idle",     4'hF, 1'b1, 4'h0, 4'h0, 4'h0, 2);
    add("k2_deb",      4'hB, 1'b1, 4'h0, 4'h0, 4'h0, 5);
    add("k2_press",    4'hB, 1'b1, 4'h4, 4'h0, 4'h4, 1);
    add("k2_delay",    4'hB, 1'b1, 4'h0, 4'h0, 4'h4, 7);
    add("k2_rep1",     4'hB, 1'b1, 4'h4, 4'h0, 4'h4, 1);
    for (int j = 0; j < 5; j++) begin
      add("k2_gap",    4'hB, 1'b1, 4'h0, 4'h0, 4'h4, 2);
      add("k2_rep",    4'hB, 1'b1, 4'h4, 4'h0, 4'h4, 1);
    end
    add("k2_gap",      4'hB, 1'b1, 4'h0, 4'h0, 4'h4, 1);
    add("k2_reldeb",   4'hF, 1'b1, 4'h0, 4'h0, 4'h4, 1);
    add("k2_reprel",   4'hF, 1'b1, 4'h4, 4'h0, 4'h4, 1);
    add("k2_reldeb",   4'hF, 1'b1, 4'h0, 4'h0, 4'h4, 2);
    add("k2_reprel",   4'hF, 1'b1, 4'h4, 4'h0, 4'h4, 1);
    add("k2_rel",      4'hF, 1'b1, 4'h0, 4'h4, 4'h0, 1);
    add("k2_after",    4'hF, 1'b1, 4'h0, 4'h0, 4'h0, 6);

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    compare("reset_state", 0, 4'h0, 4'h0, 4'h0);
    reset = 1'b1;

    foreach (tbl[i]) step(tbl[i].name, i, 1'b1, tbl[i].k, tbl[i].ren, tbl[i].p, tbl[i].r, tbl[i].h);

    // repeat_en raised while key1 already held must not start repeats
    for (int c = 1; c <= 25; c++) begin
      ep = (c == 6) ? 4'h2 : 4'h0;
      eh = (c >= 6) ? 4'h2 : 4'h0;
      step("en_late", c, 1'b1, 4'hD, (c >= 7), ep, 4'h0, eh);
    end
    for (int c = 1; c <= 8; c++)
      step("en_late_rel", c, 1'b1, 4'hF, 1'b1, 4'h0, (c == 6) ? 4'h2 : 4'h0, (c < 6) ? 4'h2 : 4'h0);

    // repeat_en dropped after the first repeat stops further repeats
    for (int c = 1; c <= 25; c++) begin
      ep = (c == 6 || c == 14) ? 4'h2 : 4'h0;
      eh = (c >= 6) ? 4'h2 : 4'h0;
      step("en_drop", c, 1'b1, 4'hD, (c <= 14), ep, 4'h0, eh);
    end
    for (int c = 1; c <= 8; c++)
      step("en_drop_rel", c, 1'b1, 4'hF, 1'b0, 4'h0, (c == 6) ? 4'h2 : 4'h0, (c < 6) ? 4'h2 : 4'h0);

    // Reset mid-repeat with key2 held, then restart from a fresh press
    for (int c = 1; c <= 21; c++) begin
      ep = (c == 6 || c == 14 || c == 17 || c == 20) ? 4'h4 : 4'h0;
      eh = (c >= 6) ? 4'h4 : 4'h0;
      step("rst_pre", c, 1'b1, 4'hB, 1'b1, ep, 4'h0, eh);
    end
    reset = 1'b0;
    #1;
    compare("rst_async", 0, 4'h0, 4'h0, 4'h0);
    for (int c = 1; c <= 3; c++) step("rst_hold", c, 1'b0, 4'hB, 1'b1, 4'h0, 4'h0, 4'h0);
    for (int c = 1; c <= 18; c++) begin
      ep = (c == 6 || c == 14 || c == 17) ? 4'h4 : 4'h0;
      eh = (c >= 6) ? 4'h4 : 4'h0;
      step("rst_post", c, 1'b1, 4'hB, 1'b1, ep, 4'h0, eh);
    end
    for (int c = 1; c <= 8; c++) begin
      ep = (c == 2 || c == 5) ? 4'h4 : 4'h0;
      er = (c == 6) ? 4'h4 : 4'h0;
      eh = (c < 6) ? 4'h4 : 4'h0;
      step("rst_rel", c, 1'b1, 4'hF, 1'b1, ep, er, eh);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 The block SHALL have parameter N, default 4, number of independent key channels (1..32).
REQ-002 The block SHALL have parameter DEBOUNCE, default 16, consecutive stable cycles required to accept a level change (>=1).
REQ-003 The block SHALL have parameter ACTIVE_LOW, default 1; when 1, key=0 means pressed.
REQ-004 The block SHALL have parameter HOLD_DELAY, default 8, cycles from press pulse to first auto-repeat pulse (>=1).
REQ-005 The block SHALL have parameter REPEAT_PERIOD, default 4, cycles between subsequent auto-repeat pulses (>=1).
REQ-006 The block SHALL have port clk  in  1  the single clock; all state SHALL be updated on its rising edge.
REQ-007 The block SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-008 The block SHALL have port repeat_en  in  1  global auto-repeat enable, sampled every cycle.
REQ-009 The block SHALL have port key  in  N  raw, asynchronous key levels.
REQ-010 The block SHALL have port press  out  N  one-cycle pulse per accepted press or auto-repeat.
REQ-011 The block SHALL have port rel  out  N  one-cycle pulse per accepted release.
REQ-012 The block SHALL have port held  out  N  debounced pressed level.

Function
REQ-013 Each channel SHALL pass key through a 2-flop synchronizer, then normalise it so 1 = pressed, per ACTIVE_LOW.
REQ-014 Each channel SHALL hold a debounced state db and a counter of width $clog2(DEBOUNCE+1).
REQ-015 When the synchronized level equals db, the counter SHALL clear to 0.
REQ-016 When the synchronized level differs from db, the counter SHALL increment; on the DEBOUNCE-th consecutive differing cycle, db SHALL take the new level and the counter SHALL clear.
REQ-017 Any return to the db level before DEBOUNCE is reached SHALL clear the counter, producing no output (glitch rejection).
REQ-018 press SHALL be registered and high for exactly the cycle in which db first reads 1; rel likewise for db first reading 0.
REQ-019 Latency: if the first edge sampling a stable new level is edge 1, db, held and press/rel SHALL update after edge DEBOUNCE+2.
REQ-020 held SHALL equal db.
REQ-021 Per-channel repeat FSM states: IDLE, DELAY, REPEAT.
REQ-022 Repeat transitions: IDLE->DELAY on press pulse with repeat_en=1; DELAY->REPEAT after HOLD_DELAY cycles, emitting press; REPEAT emits press every REPEAT_PERIOD cycles.
REQ-023 db falling or repeat_en=0 SHALL force IDLE and clear the repeat counter in the same cycle; no repeat pulse SHALL coincide with a rel pulse.
REQ-024 repeat_en rising while a key is already held SHALL NOT start repeats until the next accepted press.
REQ-025 press and rel of one channel SHALL never be high together; channels SHALL be fully independent, with simultaneous events on multiple channels all reported in the same cycle.

Reset
REQ-026 While reset=0: synchronizer flops SHALL hold the released level, db=0, all counters=0, FSMs=IDLE, press=rel=held=0.
REQ-027 A key held pressed across reset deassertion SHALL produce a normal press pulse DEBOUNCE+2 edges after reset release.
REQ-028 Reset asserted mid-debounce or mid-repeat SHALL abort immediately, with no pulse on release of reset other than per REQ-027.

Verification (N=4, DEBOUNCE=4, HOLD_DELAY=8, REPEAT_PERIOD=3, ACTIVE_LOW=1)
REQ-029 key[0] 1->0 held 20 cycles, repeat_en=0 -> press[0] single pulse 6 edges after first sampling edge, held[0]=1; no further press.
REQ-030 key[1] bounces low 3 cycles, high 1, low 3, high -> press[1]=rel[1]=held[1]=0 throughout.
REQ-031 repeat_en=1, key[2] held low 30 cycles -> press[2] at cycle P, P+8, P+11, P+14, ...; release -> rel[2] pulse and no press after.
REQ-032 key[0] and key[3] pressed on the same edge -> press[0] and press[3] pulse in the same cycle.
REQ-033 reset pulsed low mid-repeat with key still held -> outputs 0 during reset; single press 6 edges after release, then repeats restart from HOLD_DELAY.
